// File: rtl/key_mode_ctrl.sv
// Key press classification (short/long per key) and three-mode 4-LED sequencer.
// Key A events take priority; a simultaneous key B event is deferred one cycle.

module key_press_trk #(
  parameter int LONG_CNT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_flag_i,
  input  logic key_state_i,
  output logic short_o,
  output logic long_o
);
  // state  | meaning
  // T_IDLE | key released, waiting for a press edge
  // T_HELD | key pressed, hold counter running
  // T_LONG | long press already reported, waiting for release
  localparam int HW = $clog2(LONG_CNT);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CNT - 1);

  typedef enum logic [1:0] {T_IDLE, T_HELD, T_LONG} trk_e;

  trk_e          state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rel, prs;

  assign rel = key_flag_i &  key_state_i;
  assign prs = key_flag_i & ~key_state_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= T_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      T_IDLE: begin
        if (prs) begin
          state_d = T_HELD;
          hold_d  = '0;
        end
      end
      T_HELD: begin
        if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
        // a release coinciding with the long threshold reports long and returns to idle
        if (hold_q == HOLD_MAX) state_d = rel ? T_IDLE : T_LONG;
        else if (rel)           state_d = T_IDLE;
      end
      T_LONG:  if (rel) state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  always_comb begin
    short_o = (state_q == T_HELD) && (hold_q != HOLD_MAX) && rel;
    long_o  = (state_q == T_HELD) && (hold_q == HOLD_MAX);
  end
endmodule

module key_mode_ctrl #(
  parameter int LONG_CNT = 50_000_000,
  parameter int STEP_CNT = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_flag_a,
  input  logic       key_state_a,
  input  logic       key_flag_b,
  input  logic       key_state_b,
  output logic [3:0] led,
  output logic [1:0] mode
);
  // state   | meaning
  // M_MAN   | led shows the manual counter
  // M_RUN   | running light, rotates every STEP_CNT cycles unless paused
  // M_BLINK | all LEDs toggle every STEP_CNT cycles
  localparam int SW = $clog2(STEP_CNT);
  localparam logic [SW-1:0] STEP_RELOAD = SW'(STEP_CNT - 1);

  typedef enum logic [1:0] {M_MAN = 2'd0, M_RUN = 2'd1, M_BLINK = 2'd2} mode_e;

  logic a_short, a_long, b_short, b_long;

  key_press_trk #(.LONG_CNT(LONG_CNT)) u_trk_a (
    .clk(clk), .rst(rst), .key_flag_i(key_flag_a), .key_state_i(key_state_a),
    .short_o(a_short), .long_o(a_long)
  );

  key_press_trk #(.LONG_CNT(LONG_CNT)) u_trk_b (
    .clk(clk), .rst(rst), .key_flag_i(key_flag_b), .key_state_i(key_state_b),
    .short_o(b_short), .long_o(b_long)
  );

  mode_e         mode_q, mode_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    pat_q, pat_d;
  logic          dir_q, dir_d;
  logic          paused_q, paused_d;
  logic          phase_q, phase_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0]    led_q, led_d;
  logic          pa_vld_q, pa_vld_d, pa_long_q, pa_long_d;
  logic          pb_vld_q, pb_vld_d, pb_long_q, pb_long_d;
  logic          ev_vld, ev_is_b, ev_long;
  logic          a_new, b_new, step_tc, enter;

  assign a_new   = a_short | a_long;
  assign b_new   = b_short | b_long;
  assign step_tc = (step_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= M_MAN;
      cnt_q     <= '0;
      pat_q     <= 4'b0001;
      dir_q     <= 1'b0;
      paused_q  <= 1'b0;
      phase_q   <= 1'b1;
      step_q    <= STEP_RELOAD;
      led_q     <= '0;
      pa_vld_q  <= 1'b0;
      pa_long_q <= 1'b0;
      pb_vld_q  <= 1'b0;
      pb_long_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      dir_q     <= dir_d;
      paused_q  <= paused_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      led_q     <= led_d;
      pa_vld_q  <= pa_vld_d;
      pa_long_q <= pa_long_d;
      pb_vld_q  <= pb_vld_d;
      pb_long_q <= pb_long_d;
    end
  end

  // A deferred B event always goes first; an A event that collides with it waits one cycle.
  always_comb begin
    ev_vld    = 1'b0;
    ev_is_b   = 1'b0;
    ev_long   = 1'b0;
    pa_vld_d  = pa_vld_q;
    pa_long_d = pa_long_q;
    pb_vld_d  = 1'b0;
    pb_long_d = pb_long_q;
    if (pb_vld_q) begin
      ev_vld    = 1'b1;
      ev_is_b   = 1'b1;
      ev_long   = pb_long_q;
      pb_vld_d  = b_new;
      pb_long_d = b_long;
      if (a_new) begin
        pa_vld_d  = 1'b1;
        pa_long_d = a_long;
      end
    end else if (pa_vld_q) begin
      ev_vld    = 1'b1;
      ev_long   = pa_long_q;
      pa_vld_d  = a_new;
      pa_long_d = a_long;
      pb_vld_d  = b_new;
      pb_long_d = b_long;
    end else if (a_new) begin
      ev_vld    = 1'b1;
      ev_long   = a_long;
      pb_vld_d  = b_new;
      pb_long_d = b_long;
    end else if (b_new) begin
      ev_vld    = 1'b1;
      ev_is_b   = 1'b1;
      ev_long   = b_long;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    dir_d    = dir_q;
    paused_d = paused_q;
    phase_d  = phase_q;
    step_d   = step_q;
    enter    = 1'b0;

    unique case (mode_q)
      M_MAN: step_d = STEP_RELOAD;
      M_RUN: begin
        if (!paused_q) begin
          if (step_tc) begin
            step_d = STEP_RELOAD;
            pat_d  = dir_q ? {pat_q[0], pat_q[3:1]} : {pat_q[2:0], pat_q[3]};
          end else begin
            step_d = step_q - 1'b1;
          end
        end
      end
      M_BLINK: begin
        if (step_tc) begin
          step_d  = STEP_RELOAD;
          phase_d = ~phase_q;
        end else begin
          step_d = step_q - 1'b1;
        end
      end
      default: mode_d = M_MAN;
    endcase

    if (ev_vld) begin
      if (ev_long) begin
        enter = 1'b1;
        if (ev_is_b) begin
          mode_d = M_MAN;
          cnt_d  = '0;
        end else begin
          unique case (mode_q)
            M_MAN:   mode_d = M_RUN;
            M_RUN:   mode_d = M_BLINK;
            default: mode_d = M_MAN;
          endcase
        end
      end else begin
        unique case (mode_q)
          M_MAN: cnt_d = ev_is_b ? cnt_q - 4'd1 : cnt_q + 4'd1;
          M_RUN: begin
            if (ev_is_b) paused_d = ~paused_q;
            else         dir_d    = ~dir_q;
          end
          default: ;
        endcase
      end
    end

    if (enter) begin
      step_d   = STEP_RELOAD;
      pat_d    = 4'b0001;
      dir_d    = 1'b0;
      paused_d = 1'b0;
      phase_d  = 1'b1;
    end
  end

  always_comb begin
    led_d = 4'b0000;
    unique case (mode_q)
      M_MAN:   led_d = cnt_q;
      M_RUN:   led_d = pat_q;
      M_BLINK: led_d = {4{phase_q}};
      default: led_d = 4'b0000;
    endcase
  end

  assign led  = led_q;
  assign mode = mode_q;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl: directed scenarios plus a random key soak
// compared cycle by cycle against a timestamp-based behavioural model.

module tb_key_mode_ctrl;
  localparam int LONG_CNT = 20;
  localparam int STEP_CNT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fa = 1'b0, sa = 1'b1, fb = 1'b0, sb = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;

  int n_checks = 0;
  int n_errors = 0;

  key_mode_ctrl #(.LONG_CNT(LONG_CNT), .STEP_CNT(STEP_CNT)) dut (
    .clk(clk), .rst(rst),
    .key_flag_a(fa), .key_state_a(sa),
    .key_flag_b(fb), .key_state_b(sb),
    .led(led), .mode(mode)
  );

  always #5 clk = ~clk;

  // Reference model: presses tracked by timestamp, modes by plain integers.
  int         cyc;
  int         pr_at[2];
  bit         ld[2];
  int         a_wait[$];
  int         b_wait[$];
  int         m_mode, m_cnt, m_pos, m_active;
  bit         m_right, m_paused, m_phase;
  logic [3:0] exp_led;
  logic [1:0] exp_mode;

  task automatic model_reset();
    cyc = 0;
    pr_at[0] = -1; pr_at[1] = -1;
    ld[0] = 0; ld[1] = 0;
    a_wait.delete(); b_wait.delete();
    m_mode = 0; m_cnt = 0; m_pos = 0; m_active = 0;
    m_right = 0; m_paused = 0; m_phase = 1;
    exp_led = 4'h0; exp_mode = 2'd0;
  endtask

  // returns 0 none, 1 short, 2 long
  function automatic int trk(input int k, input logic f, input logic s);
    int r = 0;
    if (pr_at[k] < 0) begin
      if (f && !s) pr_at[k] = cyc;
    end else if (!ld[k]) begin
      if (cyc - pr_at[k] == LONG_CNT) begin
        r = 2;
        if (f && s) pr_at[k] = -1; else ld[k] = 1;
      end else if (f && s) begin
        r = 1;
        pr_at[k] = -1;
      end
    end else if (f && s) begin
      pr_at[k] = -1;
      ld[k] = 0;
    end
    return r;
  endfunction

  task automatic model_step();
    int ea, eb, key, kind;
    ea = trk(0, fa, sa);
    eb = trk(1, fb, sb);
    key = -1; kind = 0;
    if (b_wait.size() > 0) begin
      key = 1; kind = b_wait.pop_front();
      if (eb != 0) b_wait.push_back(eb);
      if (ea != 0) a_wait.push_back(ea);
    end else if (a_wait.size() > 0) begin
      key = 0; kind = a_wait.pop_front();
      if (ea != 0) a_wait.push_back(ea);
      if (eb != 0) b_wait.push_back(eb);
    end else if (ea != 0) begin
      key = 0; kind = ea;
      if (eb != 0) b_wait.push_back(eb);
    end else if (eb != 0) begin
      key = 1; kind = eb;
    end

    case (m_mode)
      0:       exp_led = 4'(m_cnt);
      1:       exp_led = 4'(1 << m_pos);
      default: exp_led = m_phase ? 4'hF : 4'h0;
    endcase

    if ((m_mode == 1 && !m_paused) || m_mode == 2) begin
      m_active++;
      if (m_active % STEP_CNT == 0) begin
        if (m_mode == 1) m_pos = m_right ? (m_pos + 3) % 4 : (m_pos + 1) % 4;
        else             m_phase = !m_phase;
      end
    end

    if (kind == 2) begin
      if (key == 1) begin m_mode = 0; m_cnt = 0; end
      else m_mode = (m_mode + 1) % 3;
      m_active = 0; m_pos = 0; m_right = 0; m_paused = 0; m_phase = 1;
    end else if (kind == 1) begin
      if (m_mode == 0) m_cnt = (m_cnt + ((key == 0) ? 1 : 15)) % 16;
      else if (m_mode == 1) begin
        if (key == 0) m_right = !m_right;
        else          m_paused = !m_paused;
      end
    end
    exp_mode = 2'(m_mode);
    cyc++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Drive one cycle of inputs (flags last one cycle), return at the next falling edge.
  task automatic cyc_drv(input logic f_a, input logic s_a, input logic f_b, input logic s_b);
    fa = f_a; sa = s_a; fb = f_b; sb = s_b;
    @(negedge clk);
    fa = 1'b0; fb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_drv(1'b0, sa, 1'b0, sb);
  endtask

  task automatic press_key(input bit is_b, input int dur);
    if (is_b) cyc_drv(1'b0, sa, 1'b1, 1'b0);
    else      cyc_drv(1'b1, 1'b0, 1'b0, sb);
    idle(dur - 1);
    if (is_b) cyc_drv(1'b0, sa, 1'b1, 1'b1);
    else      cyc_drv(1'b1, 1'b1, 1'b0, sb);
  endtask

  task automatic do_reset();
    rst = 1'b0; sa = 1'b1; sb = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #3;
    n_checks++;
    if (led !== 4'h0 || mode !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_hold: led=%b mode=%0d required led=0000 mode=0", led, mode);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    n_checks++;
    if (led !== 4'h0 || mode !== 2'd0 || led !== exp_led) begin
      n_errors++;
      $display("FAIL reset_idle: led=%b mode=%0d required led=0000 mode=0", led, mode);
    end
  endtask

  task automatic test_man_short();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      press_key(1'b0, 5);
      idle(2);
      n_checks++;
      if (led !== 4'(i) || led !== exp_led || mode !== 2'd0) begin
        n_errors++;
        $display("FAIL man_a_short_%0d: led=%b mode=%0d required led=%b mode=0", i, led, mode, 4'(i));
      end
    end
    do_reset();
    press_key(1'b1, 5);
    idle(2);
    n_checks++;
    if (led !== 4'hF || led !== exp_led) begin
      n_errors++;
      $display("FAIL man_b_wrap: led=%b required 1111", led);
    end
  endtask

  task automatic test_long_run();
    do_reset();
    cyc_drv(1'b1, 1'b0, 1'b0, sb);
    for (int k = 1; k <= 30; k++) begin
      if (k == 25) cyc_drv(1'b1, 1'b1, 1'b0, sb);
      else         cyc_drv(1'b0, sa, 1'b0, sb);
      if (k == 19) begin
        n_checks++;
        if (mode !== 2'd0) begin
          n_errors++;
          $display("FAIL long_early: mode=%0d required 0 at k=19", mode);
        end
      end
      if (k == 20) begin
        n_checks++;
        if (mode !== 2'd1) begin
          n_errors++;
          $display("FAIL long_mode: mode=%0d required 1 at k=20", mode);
        end
      end
      if (k == 21 || k == 25 || k == 29) begin
        n_checks++;
        if (led !== ((k == 21) ? 4'b0001 : (k == 25) ? 4'b0010 : 4'b0100)) begin
          n_errors++;
          $display("FAIL run_shift_k%0d: led=%b", k, led);
        end
      end
      n_checks++;
      if (led !== exp_led || mode !== exp_mode) begin
        n_errors++;
        $display("FAIL long_run_k%0d: led=%b mode=%0d required led=%b mode=%0d",
                 k, led, mode, exp_led, exp_mode);
      end
    end
  endtask

  task automatic test_pause_dir();
    logic [3:0] p_led;
    press_key(1'b1, 3);
    idle(2);
    p_led = exp_led;
    for (int k = 0; k < 12; k++) begin
      idle(1);
      n_checks++;
      if (led !== p_led || led !== exp_led) begin
        n_errors++;
        $display("FAIL paused_k%0d: led=%b required %b", k, led, p_led);
      end
    end
    press_key(1'b1, 3);
    for (int k = 0; k < 10; k++) begin
      idle(1);
      n_checks++;
      if (led !== exp_led || mode !== exp_mode) begin
        n_errors++;
        $display("FAIL resume_k%0d: led=%b required %b", k, led, exp_led);
      end
    end
    press_key(1'b0, 3);
    for (int k = 0; k < 12; k++) begin
      idle(1);
      n_checks++;
      if (led !== exp_led || mode !== exp_mode) begin
        n_errors++;
        $display("FAIL reverse_k%0d: led=%b required %b", k, led, exp_led);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (3) press_key(1'b0, 5);
    idle(3);
    cyc_drv(1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    cyc_drv(1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    n_checks++;
    if (led !== 4'b0100 || led !== exp_led) begin
      n_errors++;
      $display("FAIL simul_a_first: led=%b required 0100", led);
    end
    idle(1);
    n_checks++;
    if (led !== 4'b0011 || led !== exp_led) begin
      n_errors++;
      $display("FAIL simul_b_next: led=%b required 0011", led);
    end
  endtask

  task automatic test_blink();
    press_key(1'b0, 25);
    press_key(1'b0, 25);
    n_checks++;
    if (mode !== 2'd2) begin
      n_errors++;
      $display("FAIL blink_mode: mode=%0d required 2", mode);
    end
    for (int k = 0; k < 12; k++) begin
      idle(1);
      n_checks++;
      if (led !== exp_led || mode !== exp_mode) begin
        n_errors++;
        $display("FAIL blink_k%0d: led=%b required %b", k, led, exp_led);
      end
    end
    press_key(1'b1, 25);
    idle(2);
    n_checks++;
    if (mode !== 2'd0 || led !== 4'h0) begin
      n_errors++;
      $display("FAIL b_long_man: led=%b mode=%0d required led=0000 mode=0", led, mode);
    end
  endtask

  task automatic test_async_reset();
    press_key(1'b0, 25);
    idle(5);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (led !== 4'h0 || mode !== 2'd0) begin
      n_errors++;
      $display("FAIL async_reset: led=%b mode=%0d required led=0000 mode=0", led, mode);
    end
    @(negedge clk);
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_random();
    int   rem[2];
    logic fk[2];
    logic sk[2];
    do_reset();
    rem[0] = -1; rem[1] = -1;
    sk[0] = 1'b1; sk[1] = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      for (int k = 0; k < 2; k++) begin
        fk[k] = 1'b0;
        if (rem[k] < 0) begin
          if ($urandom_range(0, 19) == 0) begin
            fk[k] = 1'b1; sk[k] = 1'b0;
            rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(LONG_CNT + 1, LONG_CNT + 8))
                                                 : int'($urandom_range(1, LONG_CNT - 2));
          end else if ($urandom_range(0, 49) == 0) begin
            fk[k] = 1'b1; sk[k] = 1'b1;
          end
        end else begin
          rem[k]--;
          if (rem[k] == 0) begin
            fk[k] = 1'b1; sk[k] = 1'b1; rem[k] = -1;
          end else if ($urandom_range(0, 29) == 0) begin
            fk[k] = 1'b1; sk[k] = 1'b0;
          end
        end
      end
      cyc_drv(fk[0], sk[0], fk[1], sk[1]);
      n_checks++;
      if (led !== exp_led || mode !== exp_mode) begin
        n_errors++;
        $display("FAIL random_t%0d: led=%b mode=%0d required led=%b mode=%0d",
                 t, led, mode, exp_led, exp_mode);
      end
    end
  endtask

  initial begin
    test_reset();
    test_man_short();
    test_long_run();
    test_pause_dir();
    test_back_to_back();
    test_blink();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/key_mode_ctrl.md
Name: key_mode_ctrl

Overview:
- Controller that turns debounced key events from two key_filter instances into press classifications and sequences the 4-LED output through three display modes.
- Detects short and long presses per key and arbitrates simultaneous events with key A first.
- Runs a mode FSM covering manual counter, running light and blink.
- Drop-in replacement for led_ctrl, one level below key_led_top.

Parameters:
- LONG_CNT, 50_000_000, cycles a key must stay pressed to count as a long press (1 s at 50 MHz); must be >= 2.
- STEP_CNT, 12_500_000, cycles per running-light shift or blink toggle (250 ms at 50 MHz); must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous active-low reset.
- key_flag_a  input  1  one-cycle pulse on a debounced edge of key A.
- key_state_a  input  1  debounced level of key A; 0 = pressed, 1 = released; valid when key_flag_a=1.
- key_flag_b  input  1  as key_flag_a, for key B.
- key_state_b  input  1  as key_state_a, for key B.
- led  output  4  LED drive; 1 = lit; registered.
- mode  output  2  current mode; 0 = MAN, 1 = RUN, 2 = BLINK; 3 never occurs; registered.

Behaviour:
- Reset (rst=0, asynchronous) clears everything, including mid-press and mid-step:
  - led=0000, mode=MAN, cnt=0, pattern=0001, dir=left, paused=0.
  - Step counter, hold counters and pending event all cleared.
- Per-key press tracker (two identical instances), states IDLE / HELD / LONGDONE:
  - IDLE: flag with state=0 -> HELD, hold counter=0. Flag with state=1 is ignored.
  - HELD: hold counter increments each cycle.
    - Counter reaches LONG_CNT-1 -> emit one-cycle LONG event, go to LONGDONE.
    - Flag with state=1 before that -> emit one-cycle SHORT event, go to IDLE.
    - Flag with state=0 (duplicate press) -> ignored; counter is not restarted.
  - LONGDONE: flag with state=1 -> IDLE, no event; key remains held otherwise.
  - Hold counter saturates; it never wraps.
- Arbitration:
  - A and B events in the same cycle: A is applied that cycle; B's event is stored in a 1-deep pending register and applied the next cycle.
  - A new B event arriving while one is pending overwrites it.
  - A pending B event is applied even if a new A event arrives in the same cycle; that A event is held one cycle instead, so no event is lost except by the B overwrite rule.
- Event application:
  - Takes effect on the clock edge after the event cycle.
  - led reflects the new state one further cycle later, since led is registered from the state.
- Mode FSM, global events:
  - A LONG: MAN -> RUN -> BLINK -> MAN.
  - B LONG: -> MAN from any mode and cnt=0.
  - On every mode entry: step counter=0, pattern=0001, dir=left, paused=0. BLINK entry also sets the phase to on.
- MAN mode:
  - led=cnt.
  - A SHORT: cnt+1, wrapping 15 -> 0.
  - B SHORT: cnt-1, wrapping 0 -> 15.
  - Step counter is held at 0.
- RUN mode:
  - led=pattern.
  - Unless paused, every STEP_CNT cycles the pattern rotates one bit:
    - left: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
    - right: the reverse.
  - A SHORT toggles dir; the step counter is not reset.
  - B SHORT toggles paused; while paused the step counter holds.
- BLINK mode:
  - led=1111 when the phase is on, 0000 when off.
  - Phase toggles every STEP_CNT cycles.
  - A SHORT and B SHORT are ignored.
- cnt is retained across RUN and BLINK. Only reset or B LONG clears it.

Test Plan (LONG_CNT=20, STEP_CNT=4):
1. Reset released, no keys -> led=0000, mode=0. Assert rst=0 mid-RUN -> led=0000 and mode=0 in the same cycle, with no clock edge needed.
2. A pressed 5 cycles then released, three times -> led steps 0001, 0010, 0011. Then one B short from cnt=0 (reset first) -> led=1111.
3. A held 25 cycles -> exactly one LONG, mode=1 about 21 cycles after the press, no SHORT on release. led=0001, then 0010 four cycles later, then 0100.
4. In RUN, B short -> pattern frozen for 12 cycles. B short again -> resumes. A short -> direction reverses, e.g. 0100 -> 0010.
5. In MAN with cnt=3, A short and B short release flags in the same cycle -> cnt 4 then 3 on consecutive cycles, ending at led=0011.
6. Second A long -> mode=2, led=1111 for 4 cycles then 0000, alternating. B long -> mode=0, led=0000.
